// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for the UART async FIFO.
// Keeps binary and Gray write pointers; derives full, almost-full, level and overflow.
module fifo_wr_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = 6
) (
   input  logic                  w_clk_wr,
   input  logic                  w_rst_wr,
   input  logic                  w_inc_wr,
   input  logic                  ovf_clr_wr,
   input  logic [ADDR_WIDTH:0]   wq2_rptr_wr,
   output logic                  w_en_wr,
   output logic [ADDR_WIDTH-1:0] wr_addr_wr,
   output logic [ADDR_WIDTH:0]   wr_ptr_wr,
   output logic                  full_wr,
   output logic                  almost_full_wr,
   output logic [ADDR_WIDTH:0]   wr_level_wr,
   output logic                  ovf_wr
);

   localparam int PW = ADDR_WIDTH + 1;
   // Full when the two top Gray bits are inverted and the rest match.
   localparam logic [ADDR_WIDTH:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
   localparam logic [ADDR_WIDTH:0] AF_LVL    = PW'(AF_THRESH);

   logic [ADDR_WIDTH:0] r_wbin;
   logic [ADDR_WIDTH:0] w_wbin_next;
   logic [ADDR_WIDTH:0] w_wgray_next;
   logic [ADDR_WIDTH:0] w_rbin_sync;

   always_comb begin
      w_rbin_sync = '0;
      for (int unsigned i = 0; i < unsigned'(PW); i++) begin
         w_rbin_sync[i] = ^(wq2_rptr_wr >> i);
      end
   end

   assign full_wr        = (wr_ptr_wr == (wq2_rptr_wr ^ FULL_MASK));
   assign w_en_wr        = w_inc_wr & ~full_wr;
   assign wr_level_wr    = r_wbin - w_rbin_sync;
   assign almost_full_wr = (wr_level_wr >= AF_LVL);
   assign w_wbin_next    = r_wbin + PW'(1);
   assign w_wgray_next   = w_wbin_next ^ (w_wbin_next >> 1);

   always_ff @(posedge w_clk_wr or posedge w_rst_wr) begin
      if (w_rst_wr) begin
         r_wbin     <= '0;
         wr_ptr_wr  <= '0;
         wr_addr_wr <= '0;
         ovf_wr     <= 1'b0;
      end else begin
         if (w_en_wr) begin
            r_wbin     <= w_wbin_next;
            wr_ptr_wr  <= w_wgray_next;
            wr_addr_wr <= w_wbin_next[ADDR_WIDTH-1:0];
         end
         // A rejected write in the same cycle as a clear keeps the flag set.
         if (w_inc_wr && full_wr) begin
            ovf_wr <= 1'b1;
         end else if (ovf_clr_wr) begin
            ovf_wr <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios plus randomized traffic
// checked against a write/read entry-count model.
module tb_fifo_wr_ctrl;

   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;
   localparam int AF    = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          inc = 1'b0;
   logic          clr = 1'b0;
   logic [AW:0]   rptr = '0;
   logic          en;
   logic [AW-1:0] addr;
   logic [AW:0]   ptr;
   logic          full;
   logic          afull;
   logic [AW:0]   level;
   logic          ovf;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: total entries written and read since reset.
   int  wcount = 0;
   int  rcount = 0;
   bit  ovf_m  = 1'b0;
   logic [AW:0] prev_ptr = '0;

   fifo_wr_ctrl #(.ADDR_WIDTH(AW), .AF_THRESH(AF)) dut (
      .w_clk_wr       (clk),
      .w_rst_wr       (rst),
      .w_inc_wr       (inc),
      .ovf_clr_wr     (clr),
      .wq2_rptr_wr    (rptr),
      .w_en_wr        (en),
      .wr_addr_wr     (addr),
      .wr_ptr_wr      (ptr),
      .full_wr        (full),
      .almost_full_wr (afull),
      .wr_level_wr    (level),
      .ovf_wr         (ovf)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [AW:0] to_gray(input int n);
      logic [AW:0] b;
      b = (AW+1)'(n % (2*DEPTH));
      return b ^ (b >> 1);
   endfunction

   // One write-domain cycle: drive inputs, check every output, advance the model.
   task automatic step(input bit w, input bit c, input bit adv);
      int  lvl;
      bit  exp_full;
      bit  exp_en;
      @(negedge clk);
      if (adv && rcount < wcount) rcount++;
      inc  = w;
      clr  = c;
      rptr = to_gray(rcount);
      #1;
      lvl      = wcount - rcount;
      exp_full = (lvl == DEPTH);
      exp_en   = w && !exp_full;
      check_val("w_en",   32'(en),    32'(exp_en));
      check_val("full",   32'(full),  32'(exp_full));
      check_val("afull",  32'(afull), 32'(lvl >= AF));
      check_val("level",  32'(level), 32'(lvl));
      check_val("ptr",    32'(ptr),   32'(to_gray(wcount)));
      check_val("addr",   32'(addr),  32'(wcount % DEPTH));
      check_val("ovf",    32'(ovf),   32'(ovf_m));
      check_val("gray1",  32'($countones(ptr ^ prev_ptr) <= 1), 32'd1);
      prev_ptr = ptr;
      if (exp_en) wcount++;
      if (w && exp_full) ovf_m = 1'b1;
      else if (c) ovf_m = 1'b0;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      inc = 1'b0;
      clr = 1'b0;
      #2;
      rst  = 1'b1;
      rcount = 0;
      rptr = '0;
      #1;
      check_val("rst_ptr",   32'(ptr),   32'd0);
      check_val("rst_addr",  32'(addr),  32'd0);
      check_val("rst_ovf",   32'(ovf),   32'd0);
      check_val("rst_full",  32'(full),  32'd0);
      check_val("rst_afull", 32'(afull), 32'd0);
      check_val("rst_level", 32'(level), 32'd0);
      check_val("rst_en",    32'(en),    32'd0);
      #1;
      rst    = 1'b0;
      wcount = 0;
      ovf_m  = 1'b0;
      prev_ptr = '0;
   endtask

   logic [AW:0] gray_tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100};

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0);

      // Fill with back-to-back writes, checking the Gray sequence right after each edge.
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0);
         @(posedge clk);
         #1;
         check_val("fill_ptr", 32'(ptr), 32'(gray_tbl[i]));
         if (i == 5) check_val("af_6th", 32'(afull), 32'd1);
      end
      check_val("full8",  32'(full),  32'd1);
      check_val("lvl8",   32'(level), 32'd8);
      check_val("addr8",  32'(addr),  32'd0);

      // Rejected writes, overflow set/clear priority.
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 1, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      check_val("ovf_cleared", 32'(ovf), 32'd0);

      // Read advance and write in the same cycle while full.
      step(1, 0, 1);
      @(posedge clk);
      #1;
      check_val("rel_ptr",  32'(ptr),   32'b1101);
      check_val("rel_full", 32'(full),  32'd1);
      check_val("rel_lvl",  32'(level), 32'd8);

      // Wrap: drain, then interleave writes and reads until the pointer returns to 0.
      reset_pulse();
      for (int i = 0; i < 16; i++) begin
         step(1, 0, (i % 2) == 1);
      end
      step(0, 0, 1);
      check_val("wrap_ptr", 32'(ptr), 32'd0);

      // Asynchronous reset after five writes.
      reset_pulse();
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      reset_pulse();
      step(0, 0, 0);

      // Randomized traffic in phases of differing write/read pressure.
      for (int ph = 0; ph < 12; ph++) begin
         int wp;
         int rp;
         wp = $urandom_range(20, 95);
         rp = $urandom_range(5, 90);
         for (int k = 0; k < 200; k++) begin
            step($urandom_range(0, 99) < wp,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 99) < rp);
         end
         if (ph % 4 == 3) reset_pulse();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
